cla_mp_seq: RTL and testbench



---
 rtl/cla_mp_seq_if.sv | 44 ++++
 rtl/cla_mp_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_cla_mp_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cla_mp_seq_if.sv
// cla_mp_seq_if: request/response bundle between a wide-arithmetic control
// master and the multi-precision add/subtract sequencer.
interface cla_mp_seq_if #(
  parameter int WORDS = 4
) ();

  // request side, driven by the master
  logic                  start;
  logic                  sub;
  logic [32*WORDS-1:0]   a;
  logic [32*WORDS-1:0]   b;

  // response side, driven by the sequencer
  logic                  busy;
  logic                  done;
  logic [32*WORDS-1:0]   result;
  logic                  cout;
  logic                  ovf;

  modport master (
    output start,
    output sub,
    output a,
    output b,
    input  busy,
    input  done,
    input  result,
    input  cout,
    input  ovf
  );

  modport slave (
    input  start,
    input  sub,
    input  a,
    input  b,
    output busy,
    output done,
    output result,
    output cout,
    output ovf
  );

endinterface

// File: rtl/cla_mp_seq.sv
// cla_mp_seq: multi-precision add/subtract sequencer. One 32-bit
// carry-lookahead adder is reused across WORDS limbs, least-significant
// first, with the inter-limb carry held in a register so the carry path
// per cycle is a single adder plus a flop.

// bit32cla: 32-bit two-level carry-lookahead adder (4-bit groups, 8 groups).
module bit32cla (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_c;
  logic [7:0]  w_gg;
  logic [7:0]  w_gp;
  logic [8:0]  w_gc;

  // bit-level generate/propagate and group-level generate/propagate
  always_comb begin
    w_g = i_a & i_b;
    w_p = i_a ^ i_b;
    w_gg = 8'h00;
    w_gp = 8'h00;
    for (int k = 0; k < 8; k++) begin
      w_gp[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
    end
  end

  // group carries from the group terms, then bit carries inside each group
  always_comb begin
    w_gc = 9'h000;
    w_c  = 32'h0000_0000;
    w_gc[0] = i_cin;
    for (int k = 0; k < 8; k++) begin
      w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
    end
    for (int k = 0; k < 8; k++) begin
      w_c[4*k]   = w_gc[k];
      w_c[4*k+1] = w_g[4*k]   | (w_p[4*k]   & w_gc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
    end
  end

  // sum and carry out
  always_comb begin
    o_sum  = w_p ^ w_c;
    o_cout = w_gc[8];
  end

endmodule

module cla_mp_seq #(
  parameter int WORDS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  cla_mp_seq_if.slave bus
);

  localparam int W    = 32 * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_result;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;
  logic            r_done;
  logic [IDXW-1:0] r_idx;

  logic [W-1:0]    w_a_sh;
  logic [W-1:0]    w_b_sh;
  logic [31:0]     w_a_limb;
  logic [31:0]     w_b_limb;
  logic [31:0]     w_sum;
  logic            w_cout;
  logic            w_busy;
  logic            w_accept;
  logic            w_last;

  // select the current limb of each captured operand
  always_comb begin
    w_a_sh   = r_a >> {r_idx, 5'b00000};
    w_b_sh   = r_b >> {r_idx, 5'b00000};
    w_a_limb = w_a_sh[31:0];
    w_b_limb = w_b_sh[31:0];
  end

  bit32cla u_cla (
    .i_a    (w_a_limb),
    .i_b    (w_b_limb),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_idx == LAST) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // state decode: busy in RUN, accept only from IDLE, last-limb flag
  always_comb begin
    w_busy   = 1'b0;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = bus.start;
      end
      S_RUN: begin
        w_busy = 1'b1;
        w_last = (r_idx == LAST);
      end
      default: begin
        w_busy   = 1'b0;
        w_accept = 1'b0;
        w_last   = 1'b0;
      end
    endcase
  end

  // operand capture, limb-by-limb result write and completion flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // subtraction is a + ~b + 1: invert b here, inject the +1 as carry-in
        r_a     <= bus.a;
        r_b     <= bus.sub ? ~bus.b : bus.b;
        r_carry <= bus.sub;
        r_idx   <= '0;
        r_cout  <= 1'b0;
        r_ovf   <= 1'b0;
      end else if (w_busy) begin
        for (int k = 0; k < WORDS; k++) begin
          if (r_idx == IDXW'(k)) begin
            r_result[32*k +: 32] <= w_sum;
          end
        end
        r_carry <= w_cout;
        if (w_last) begin
          // index parks on the top limb; the next accept clears it
          r_cout <= w_cout;
          r_done <= 1'b1;
          // b is already inverted for sub, so one rule covers both ops
          r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_sum[31] != r_a[W-1]);
        end else begin
          r_idx <= r_idx + IDXW'(1);
        end
      end
    end
  end

  // drive the response side from registered state
  always_comb begin
    bus.busy   = w_busy;
    bus.done   = r_done;
    bus.result = r_result;
    bus.cout   = r_cout;
    bus.ovf    = r_ovf;
  end

endmodule

// File: tb/tb_cla_mp_seq.sv
// tb_cla_mp_seq: randomized and directed checks of cla_mp_seq at WORDS=4
// and WORDS=1 against a plain-arithmetic reference model.
module tb_cla_mp_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cla_mp_seq_if #(.WORDS(4)) if4 ();
  cla_mp_seq_if #(.WORDS(1)) if1 ();

  cla_mp_seq #(.WORDS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  cla_mp_seq #(.WORDS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // count one comparison and report it if it does not match
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // reference: {ovf, cout, result} of a w-bit add or subtract
  function automatic logic [129:0] model(input logic s, input int w,
                                         input logic [127:0] a_in, input logic [127:0] b_in);
    logic [127:0] mask;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] res;
    logic [128:0] full;
    logic         co;
    logic         ov;
    logic         sa;
    logic         sb;
    logic         sr;
    mask = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
    a = a_in & mask;
    b = b_in & mask;
    if (!s) begin
      full = {1'b0, a} + {1'b0, b};
      res  = full[127:0] & mask;
      co   = full[w];
    end else begin
      res = (a - b) & mask;
      co  = (a >= b);
    end
    sa = a[w-1];
    sb = b[w-1];
    sr = res[w-1];
    ov = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {ov, co, res};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one WORDS=4 op started from the current cycle; returns in the done cycle
  task automatic op4(input logic s, input logic [127:0] a, input logic [127:0] b,
                     input bit inject, input string tag);
    logic [129:0] exp;
    int cyc;
    exp = model(s, 128, a, b);
    if4.start = 1'b1;
    if4.sub   = s;
    if4.a     = a;
    if4.b     = b;
    tick();
    if4.start = 1'b0;
    if4.sub   = ~s;
    if4.a     = rnd128();
    if4.b     = rnd128();
    check({tag, "/busy_after_start"}, 128'(if4.busy), 128'd1);
    check({tag, "/cout_cleared"}, 128'(if4.cout), 128'd0);
    check({tag, "/ovf_cleared"}, 128'(if4.ovf), 128'd0);
    cyc = 0;
    while (!if4.done && cyc < 16) begin
      if (inject && cyc == 1) begin
        if4.start = 1'b1;
        if4.sub   = ~s;
        if4.a     = rnd128();
        if4.b     = rnd128();
      end else begin
        if4.start = 1'b0;
      end
      tick();
      cyc++;
      if (!if4.done) check({tag, "/busy_mid"}, 128'(if4.busy), 128'd1);
    end
    if4.start = 1'b0;
    check({tag, "/latency"}, 128'(cyc), 128'd4);
    check({tag, "/done"}, 128'(if4.done), 128'd1);
    check({tag, "/busy_at_done"}, 128'(if4.busy), 128'd0);
    check({tag, "/result"}, if4.result, exp[127:0]);
    check({tag, "/cout"}, 128'(if4.cout), 128'(exp[128]));
    check({tag, "/ovf"}, 128'(if4.ovf), 128'(exp[129]));
  endtask

  // one WORDS=1 op: done must follow the start edge by exactly one cycle
  task automatic op1(input logic s, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [129:0] exp;
    exp = model(s, 32, 128'(a), 128'(b));
    if1.start = 1'b1;
    if1.sub   = s;
    if1.a     = a;
    if1.b     = b;
    tick();
    if1.start = 1'b0;
    check({tag, "/busy"}, 128'(if1.busy), 128'd1);
    tick();
    check({tag, "/done"}, 128'(if1.done), 128'd1);
    check({tag, "/busy_at_done"}, 128'(if1.busy), 128'd0);
    check({tag, "/result"}, 128'(if1.result), exp[127:0]);
    check({tag, "/cout"}, 128'(if1.cout), 128'(exp[128]));
    check({tag, "/ovf"}, 128'(if1.ovf), 128'(exp[129]));
    tick();
    check({tag, "/done_fall"}, 128'(if1.done), 128'd0);
  endtask

  initial begin
    logic [127:0] ones;
    logic [127:0] maxpos;
    logic [127:0] minneg;
    logic [127:0] ra;
    logic [127:0] rb;
    bit           seen;

    ones   = '1;
    maxpos = {1'b0, {127{1'b1}}};
    minneg = {1'b1, 127'd0};

    rst_n = 1'b0;
    if4.start = 1'b0; if4.sub = 1'b0; if4.a = '0; if4.b = '0;
    if1.start = 1'b0; if1.sub = 1'b0; if1.a = '0; if1.b = '0;
    tick();
    tick();
    check("reset/busy4", 128'(if4.busy), 128'd0);
    check("reset/done4", 128'(if4.done), 128'd0);
    check("reset/result4", if4.result, 128'd0);
    check("reset/cout4", 128'(if4.cout), 128'd0);
    check("reset/ovf4", 128'(if4.ovf), 128'd0);
    check("reset/result1", 128'(if1.result), 128'd0);
    rst_n = 1'b1;
    tick();

    op4(1'b0, ones, 128'd1, 1'b0, "add_wrap");
    tick();
    check("add_wrap/done_fall", 128'(if4.done), 128'd0);
    op4(1'b1, 128'd0, 128'd1, 1'b0, "sub_borrow");
    tick();
    op4(1'b0, maxpos, 128'd1, 1'b0, "add_ovf");
    tick();
    op4(1'b1, minneg, 128'd1, 1'b0, "sub_ovf");
    tick();
    op4(1'b0, rnd128(), rnd128(), 1'b1, "ignore_start");
    tick();
    check("ignore_start/idle_after", 128'(if4.busy), 128'd0);

    op4(1'b0, 128'd10, 128'd20, 1'b0, "b2b_first");
    op4(1'b1, 128'd5, 128'd3, 1'b0, "b2b_second");
    tick();
    check("b2b/done_fall", 128'(if4.done), 128'd0);

    // abort in the middle of limb 2
    if4.start = 1'b1; if4.sub = 1'b0; if4.a = ones; if4.b = ones;
    tick();
    if4.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort/busy", 128'(if4.busy), 128'd0);
    check("abort/done", 128'(if4.done), 128'd0);
    check("abort/result", if4.result, 128'd0);
    check("abort/cout", 128'(if4.cout), 128'd0);
    check("abort/ovf", 128'(if4.ovf), 128'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if4.done || if4.busy) seen = 1'b1;
    end
    check("abort/no_done", 128'(seen), 128'd0);
    op4(1'b0, rnd128(), rnd128(), 1'b0, "after_abort");
    tick();

    for (int i = 0; i < 24; i++) begin
      ra = rnd128();
      case ($urandom_range(0, 3))
        0:       rb = ~ra;
        1:       rb = ones;
        default: rb = rnd128();
      endcase
      op4(1'($urandom_range(0, 1)), ra, rb, ($urandom_range(0, 3) == 0), "rand4");
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();

    op1(1'b1, 32'd0, 32'd1, "w1_sub_borrow");
    op1(1'b0, 32'h7FFF_FFFF, 32'd1, "w1_add_ovf");
    op1(1'b0, 32'hFFFF_FFFF, 32'd1, "w1_add_wrap");
    for (int i = 0; i < 12; i++) begin
      op1(1'($urandom_range(0, 1)), $urandom, $urandom, "rand1");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
